// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder: FSM state encoding and default width.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_RUN  = 2'd1;
    localparam state_t S_DONE = 2'd2;

endpackage

// File: rtl/serial_adder_fulladder.sv
// One-bit full-adder cell used by the serial adder datapath.
module serial_adder_fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell processes operands LSB first, one bit per clock.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             carry;
    logic [WIDTH-2:0] res_sr;
    logic             fa_s;
    logic             fa_cout;
    logic [WIDTH-1:0] res_next;

    serial_adder_fulladder u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_cout)
    );

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
    assign res_next = {fa_s, res_sr};

    // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            a_sr   <= '0;
            b_sr   <= '0;
            carry  <= 1'b0;
            res_sr <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            // Status flags are registered from the current state, one cycle behind it.
            busy <= (state != S_IDLE);
            done <= (state == S_DONE);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sr   <= a;
                        b_sr   <= b;
                        carry  <= cin;
                        cnt    <= '0;
                        res_sr <= '0;
                        state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    carry  <= fa_cout;
                    res_sr <= res_next[WIDTH-1:1];
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST_BIT) begin
                        sum   <= res_next;
                        cout  <= fa_cout;
                        state <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed and randomized checks for serial_adder at WIDTH=8.
module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int checks   = 0;
    int failures = 0;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Full operation with operand scrambling after acceptance; called at a negedge with DUT idle.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                          input string tag);
        logic [8:0] exp;
        logic [7:0] prev_sum;
        int         lat;
        bit         seen;
        bit         moved;
        exp = {1'b0, ta} + {1'b0, tb_v} + {8'd0, tc};
        a = ta; b = tb_v; cin = tc; start = 1'b1;
        cycle();
        start = 1'b0; a = ~ta; b = ta ^ 8'h5A; cin = ~tc;
        prev_sum = sum; lat = 0; seen = 0; moved = 0;
        for (int n = 1; n <= 30 && !seen; n++) begin
            cycle();
            if (n < WIDTH && sum !== prev_sum) moved = 1;
            if (n == 1) check({tag, "_busy_first"}, {31'd0, busy}, 32'd1);
            if (done === 1'b1) begin
                seen = 1;
                lat  = n;
            end
        end
        check({tag, "_latency"}, lat, WIDTH + 1);
        check({tag, "_sum"}, {24'd0, sum}, {24'd0, exp[7:0]});
        check({tag, "_cout"}, {31'd0, cout}, {31'd0, exp[8]});
        check({tag, "_sum_stable"}, {31'd0, moved}, 32'd0);
        check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd1);
        cycle();
        check({tag, "_done_width"}, {31'd0, done}, 32'd0);
        check({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [8:0] exp_q[$];
        logic [8:0] e;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        @(negedge clk);
        cycle();
        cycle();
        rst = 1'b0;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_sum", {24'd0, sum}, 32'd0);
        check("reset_cout", {31'd0, cout}, 32'd0);
        cycle();

        run_op(8'h00, 8'h00, 1'b0, "zero");
        run_op(8'hFF, 8'h01, 1'b0, "ff_plus_1");
        run_op(8'hA5, 8'h5A, 1'b1, "a5_5a_c1");
        run_op(8'h3C, 8'h0F, 1'b0, "3c_0f");

        // Start held high, operands change every cycle; accepts land on cycles 0, 10, 20.
        for (int i = 0; i < 30; i++) begin
            a = 8'(i * 37 + 5); b = 8'hC3; cin = 1'(i / 10); start = 1'b1;
            if (i % 10 == 0) exp_q.push_back({1'b0, a} + {1'b0, b} + {8'd0, cin});
            cycle();
            if (i % 10 == 9) begin
                e = exp_q.pop_front();
                check($sformatf("stream_done_%0d", i), {31'd0, done}, 32'd1);
                check($sformatf("stream_res_%0d", i), {23'd0, cout, sum}, {23'd0, e});
            end else begin
                check($sformatf("stream_nodone_%0d", i), {31'd0, done}, 32'd0);
            end
        end
        start = 1'b0;
        cycle();
        cycle();

        // Abort in the 4th RUN cycle after a known 0x4B result.
        run_op(8'h3C, 8'h0F, 1'b0, "pre_abort");
        a = 8'h12; b = 8'h34; cin = 1'b1; start = 1'b1;
        cycle();
        start = 1'b0;
        cycle();
        cycle();
        cycle();
        check("abort_sum_held", {24'd0, sum}, 32'h4B);
        check("abort_busy_run", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_sum", {24'd0, sum}, 32'd0);
        check("abort_cout", {31'd0, cout}, 32'd0);
        begin
            bit pulsed = 0;
            for (int n = 0; n < 12; n++) begin
                cycle();
                if (done !== 1'b0) pulsed = 1;
            end
            check("abort_no_done", {31'd0, pulsed}, 32'd0);
        end
        run_op(8'h80, 8'h80, 1'b1, "post_abort");

        for (int i = 0; i < 500; i++) begin
            run_op(8'($urandom), 8'($urandom), 1'($urandom), $sformatf("rand_%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
